// File: rtl/mips_run_ctrl_if.sv
// Register-dump stream from mips_run_ctrl (master) to a snapshot consumer (slave).
interface mips_run_ctrl_if #(
   parameter int unsigned REG_W = 32
);
   logic             dump_valid;
   logic             dump_ready;
   logic [4:0]       dump_idx;
   logic [REG_W-1:0] dump_data;

   modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
   modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset sequencing, gated run, halt/budget stop,
// optional register-file dump (enabled by defining MIPS_RUN_DUMP_EN).
module mips_run_ctrl #(
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned MAX_CYCLES = 100,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned PC_W       = 32,
   parameter int unsigned REG_W      = 32,
   parameter int unsigned NREGS      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  halt_pc,
   input  logic [PC_W-1:0]  pc,
   output logic             core_reset,
   output logic             core_en,
   output logic [4:0]       reg_rd_addr,
   input  logic [REG_W-1:0] reg_rd_data,
   mips_run_ctrl_if.master  dump,
   output logic [CNT_W-1:0] cycle_count,
   output logic             busy,
   output logic             done,
   output logic             timeout
);
   localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int unsigned IDX_W = 5;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

   typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DUMP, S_DONE} state_e;

`ifdef MIPS_RUN_DUMP_EN
   localparam state_e S_RUN_EXIT = S_DUMP;
`else
   localparam state_e S_RUN_EXIT = S_DONE;
`endif

   state_e             state_q, state_d;
   logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
   logic               timeout_q, timeout_d;
   logic               core_reset_q, core_reset_d;
   logic               core_en_q, core_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               halt_c, budget_c, dump_last_c;

   assign halt_c   = (pc == halt_pc);
   assign budget_c = (cycle_count_q == CNT_W'(MAX_CYCLES - 1));

   // State and registered-output flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         rst_cnt_q     <= '0;
         cycle_count_q <= '0;
         timeout_q     <= 1'b0;
         core_reset_q  <= 1'b1;
         core_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         cycle_count_q <= cycle_count_d;
         timeout_q     <= timeout_d;
         core_reset_q  <= core_reset_d;
         core_en_q     <= core_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   // Next-state: halt takes priority over budget
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE,
         S_DONE:  if (start) state_d = S_RESET;
         S_RESET: if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d = S_RUN;
         S_RUN:   if (halt_c || budget_c) state_d = S_RUN_EXIT;
         S_DUMP:  if (dump_last_c) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Counters and registered outputs; a halting cycle does not execute, so it is not counted
   always_comb begin
      rst_cnt_d     = '0;
      cycle_count_d = cycle_count_q;
      timeout_d     = timeout_q;
      case (state_q)
         S_IDLE,
         S_DONE: begin
            if (start) begin
               cycle_count_d = '0;
               timeout_d     = 1'b0;
            end
         end
         S_RESET: rst_cnt_d = rst_cnt_q + RST_W'(1);
         S_RUN: begin
            if (!halt_c) begin
               if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_W'(1);
               if (budget_c) timeout_d = 1'b1;
            end
         end
         default: ;
      endcase
      core_reset_d = (state_d == S_IDLE) || (state_d == S_RESET);
      core_en_d    = (state_d == S_RESET) || (state_d == S_RUN);
      busy_d       = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_DUMP);
      done_d       = (state_d == S_DONE);
   end

   assign core_reset  = core_reset_q;
   assign core_en     = core_en_q & ~((state_q == S_RUN) & halt_c);
   assign cycle_count = cycle_count_q;
   assign timeout     = timeout_q;
   assign busy        = busy_q;
   assign done        = done_q;

`ifdef MIPS_RUN_DUMP_EN
   logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
   logic             dump_valid_q;
   logic             dump_xfer_c;

   assign dump_xfer_c = dump_valid_q & dump.dump_ready;
   assign dump_last_c = dump_xfer_c & (dump_idx_q == LAST_IDX);

   // Index holds while the consumer stalls and restarts at 0 on every dump
   always_comb begin
      dump_idx_d = '0;
      if (state_q == S_DUMP) begin
         dump_idx_d = dump_idx_q;
         if (dump_xfer_c && !dump_last_c) dump_idx_d = dump_idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dump_idx_q   <= '0;
         dump_valid_q <= 1'b0;
      end else begin
         dump_idx_q   <= dump_idx_d;
         dump_valid_q <= (state_d == S_DUMP);
      end
   end

   assign reg_rd_addr     = dump_idx_q;
   assign dump.dump_idx   = dump_idx_q;
   assign dump.dump_valid = dump_valid_q;
   assign dump.dump_data  = dump_valid_q ? reg_rd_data : '0;
`else
   logic unused_c;

   assign dump_last_c     = 1'b0;
   assign unused_c        = ^{reg_rd_data, dump.dump_ready, LAST_IDX};
   assign reg_rd_addr     = '0;
   assign dump.dump_idx   = '0;
   assign dump.dump_valid = 1'b0;
   assign dump.dump_data  = '0;
`endif

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller for the single-cycle MIPS core; replaces fixed-delay reset and stop timing with parametrised hardware sequencing.
- Generates the core's reset pulse, gates execution with a clock enable, and stops on a halt PC or a cycle budget.
- Then streams a register-file snapshot out over a valid/ready port.
- Sits between board/bench control and the MIPS top level.

Parameters:
- RST_CYCLES, 2: cycles core_reset is held high after start (≥1).
- MAX_CYCLES, 100: cycle budget in RUN before timeout (≥1, < 2^CNT_W).
- CNT_W, 16: width of cycle_count.
- PC_W, 32: program counter width.
- REG_W, 32: register data width.
- NREGS, 32: registers dumped, indices 0..NREGS-1 (≤32).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low controller reset.
- start  in  1  begin a run; accepted only in IDLE or DONE.
- halt_pc  in  PC_W  address that ends the run when fetched.
- pc  in  PC_W  core's current PC.
- core_reset  out  1  active-high synchronous reset to the core.
- core_en  out  1  core clock enable.
- reg_rd_addr  out  5  register-file debug read address.
- reg_rd_data  in  REG_W  combinational register-file read data.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the dump word.
- dump_idx  out  5  register index of the current dump word.
- dump_data  out  REG_W  register value of the current dump word.
- cycle_count  out  CNT_W  core cycles executed in the last/current run.
- busy  out  1  high in RESET, RUN, DUMP.
- done  out  1  high in DONE.
- timeout  out  1  run ended on budget, not on halt.

Behaviour:
- States: IDLE, RESET, RUN, DUMP, DONE.
- reset low, asynchronous:
  - state=IDLE, core_reset=1, core_en=0.
  - cycle_count=0, timeout=0, done=0, busy=0.
  - dump_valid=0, dump_idx=0, reg_rd_addr=0.
  - An assertion mid-run aborts the run immediately; no dump.
- IDLE:
  - core_reset=1, core_en=0.
  - start=1 → RESET next edge; cycle_count and timeout cleared on that edge.
- RESET:
  - core_reset=1, core_en=1 so the core's synchronous reset takes effect.
  - Internal counter runs RST_CYCLES cycles, then → RUN.
- RUN:
  - core_reset=0, core_en=1.
  - cycle_count increments each cycle; saturates at 2^CNT_W-1.
  - pc==halt_pc → DUMP; the halting instruction is not executed, so core_en=0 combinationally that cycle.
  - Else cycle_count==MAX_CYCLES-1 → DUMP with timeout=1 on that edge; that cycle's instruction is executed.
  - Halt and budget in the same cycle → halt wins, timeout=0.
  - start ignored.
- DUMP:
  - core_en=0, core_reset=0; core state frozen.
  - reg_rd_addr=dump_idx; dump_data=reg_rd_data (combinational passthrough); dump_valid=1.
  - On dump_valid && dump_ready: dump_idx increments.
  - Transfer of index NREGS-1 → DONE, dump_valid=0 next cycle.
  - dump_idx/dump_data hold stable while !dump_ready.
- DONE:
  - done=1; core_en=0, core_reset=0; registers stay inspectable.
  - cycle_count and timeout hold.
  - start=1 → RESET; done cleared, counters cleared.
- cycle_count semantics: equals the number of RUN cycles with core_en=1.
- All outputs except dump_data and the RUN-state core_en are registered.

Optional Feature:
- Macro MIPS_RUN_DUMP_EN.
- Defined: DUMP state as above.
- Undefined:
  - RUN → DONE directly.
  - dump_valid, dump_idx, dump_data, reg_rd_addr tied 0; dump_ready ignored.
  - reg_rd_data unused.

Test Plan:
1. reset low for 1 cycle then high, start pulse, RST_CYCLES=2 → core_reset high exactly 2 cycles after start accepted, then core_en=1, busy=1.
2. pc reaches halt_pc=0x0000_0010 after 4 RUN cycles, dump_ready=1 → cycle_count=4, timeout=0; dump_idx 0..31 on 32 consecutive cycles with dump_data matching the model register file; done=1 after index 31.
3. halt_pc never hit, MAX_CYCLES=100 → transition after 100 RUN cycles, cycle_count=100, timeout=1, core_en=0 from the next cycle.
4. DUMP with dump_ready low 3 cycles on index 5 → dump_idx=5 and dump_data held stable; advances to 6 only on the cycle dump_ready=1.
5. reset driven low asynchronously mid-RUN (cycle 37) → core_reset=1, core_en=0, state IDLE, cycle_count=0 without waiting for a clock edge. Then start from DONE → second run re-clears cycle_count and timeout.
6. MIPS_RUN_DUMP_EN undefined, halt → DONE one cycle after halt; dump_valid never asserted.
